// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding an 8N1 serial transmitter, MSB first, idle-high line.
// Each bit period lasts CLKS_PER_BIT clocks; tx is driven straight from a flop.
module uart_tx_queue #(
    parameter int CLKS_PER_BIT = 1,
    parameter int DEPTH        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       busy,
    output logic       tx
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_C  = DEPTH[AW:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        r_state;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_shift;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_idx;
    logic          r_tx;

    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_period_done;

    // Acceptance looks at full before any pop in the same cycle.
    assign w_full        = (r_count == DEPTH_C);
    assign w_push        = wr_en && !w_full;
    assign w_pop         = (r_state == IDLE) && (r_count != '0);
    assign w_period_done = (r_clk_cnt == LAST_CNT);

    assign full = w_full;
    assign busy = (r_state != IDLE) || (r_count != '0);
    assign tx   = r_tx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_tx      <= 1'b1;
            r_shift   <= '0;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx      <= 1'b1;
                    r_clk_cnt <= '0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_period_done) begin
                        r_tx      <= r_shift[7];
                        r_shift   <= {r_shift[6:0], 1'b0};
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_period_done) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_tx      <= r_shift[7];
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_period_done) begin
                        r_clk_cnt <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: a line-level model checked every cycle, plus
// hand-computed waveform checks and a behavioural serial receiver on tx.
module tb_uart_tx_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       full, busy, tx;
    logic       rst4 = 1'b1, wr_en4 = 1'b0;
    logic [7:0] wr_data4 = '0;
    logic       full4, busy4, tx4;

    uart_tx_queue #(.CLKS_PER_BIT(1), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .busy(busy), .tx(tx)
    );

    uart_tx_queue #(.CLKS_PER_BIT(4), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst4), .wr_en(wr_en4), .wr_data(wr_data4),
        .full(full4), .busy(busy4), .tx(tx4)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // hist[n] is the line level present when edge n arrives.
    logic hist  [0:1023];
    logic hist4 [0:1023];

    // Model: byte queue plus the queue of line levels still to be shown.
    logic [7:0] m_q[$];
    logic       m_line[$];
    logic       m_tx = 1'b1, m_busy = 1'b0, m_full = 1'b0, m_valid = 1'b0;
    int         m_pre;
    logic [7:0] m_byte;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_q.delete();
                m_line.delete();
                m_tx    = 1'b1;
                m_valid = 1'b1;
            end else if (m_valid) begin
                m_pre = m_q.size();
                if (m_line.size() == 0 && m_pre > 0) begin
                    m_byte = m_q.pop_front();
                    m_line.push_back(1'b0);
                    for (int i = 7; i >= 0; i--) m_line.push_back(m_byte[i]);
                    m_line.push_back(1'b1);
                    m_line.push_back(1'b1);
                end
                if (wr_en && m_pre < 4) m_q.push_back(wr_data);
                if (m_line.size() > 0) m_tx = m_line.pop_front();
                else m_tx = 1'b1;
            end
            m_busy = (m_line.size() > 0) || (m_q.size() > 0);
            m_full = (m_q.size() == 4);
        end
    end

    // Behavioural receiver on the CLKS_PER_BIT=1 line.
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh = '0, rx_data = '0;
    logic       rx_rdy = 1'b0;
    int         rx_cnt = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid && tx === 1'b0) begin
                rx_rdy = 1'b0;
                for (int b = 0; b < 8; b++) begin
                    @(negedge clk);
                    rx_sh = {rx_sh[6:0], tx};
                end
                @(negedge clk);
                if (tx === 1'b1) begin
                    rx_data = rx_sh;
                    rx_rdy  = 1'b1;
                    rx_q.push_back(rx_sh);
                    rx_cnt++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: outputs are compared against the model at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (cyc + 1 < 1024) begin
            hist[cyc+1]  = tx;
            hist4[cyc+1] = tx4;
        end
        if (m_valid) begin
            check("model_tx", {31'd0, tx}, {31'd0, m_tx});
            check("model_busy", {31'd0, busy}, {31'd0, m_busy});
            check("model_full", {31'd0, full}, {31'd0, m_full});
        end
    endtask

    task automatic wr(input logic [7:0] d, output int edge_n);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        edge_n  = cyc;
        wr_en   = 1'b0;
    endtask

    int         k, k4, r, base, zeros, dummy;
    logic [7:0] a5_bits;
    logic [7:0] ovf_exp [5] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};

    initial begin
        // Reset held for two edges on both instances.
        tick();
        tick();
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_full", {31'd0, full}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset4_tx", {31'd0, tx4}, 32'd1);
        check("reset4_busy", {31'd0, busy4}, 32'd0);
        rst  = 1'b0;
        rst4 = 1'b0;
        tick();

        // Single byte 0xA5.
        wr(8'hA5, k);
        repeat (14) tick();
        a5_bits = 8'b1010_0101;
        check("a5_start", {31'd0, hist[k+2]}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("a5_bit", {31'd0, hist[k+3+i]}, {31'd0, a5_bits[7-i]});
        end
        check("a5_stop", {31'd0, hist[k+11]}, 32'd1);
        check("a5_busy_after", {31'd0, busy}, 32'd0);

        // Overflow: six back-to-back writes, the sixth must be dropped.
        base = rx_q.size();
        for (int i = 0; i < 6; i++) begin
            wr(8'h11 + 8'(i), dummy);
            if (i == 4) check("ovf_full_5th", {31'd0, full}, 32'd1);
        end
        repeat (70) tick();
        check("ovf_busy_after", {31'd0, busy}, 32'd0);
        check("ovf_rx_count", rx_q.size() - base, 32'd5);
        for (int j = 0; j < 5; j++) begin
            if (base + j < rx_q.size()) check("ovf_rx_byte", {24'd0, rx_q[base+j]}, {24'd0, ovf_exp[j]});
            else check("ovf_rx_missing", 32'd0, 32'd1);
        end

        // Reset during DATA bit 3 of 0xFF with two bytes queued.
        wr(8'hFF, k);
        wr(8'hAA, dummy);
        wr(8'h55, dummy);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        r = cyc;
        check("mid_rst_tx", {31'd0, tx}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_full", {31'd0, full}, 32'd0);
        repeat (30) tick();
        zeros = 0;
        for (int j = r + 1; j <= r + 30; j++) if (hist[j] == 1'b0) zeros++;
        check("mid_rst_no_start", zeros, 32'd0);

        // Baud scaling on the CLKS_PER_BIT=4 instance: 0x01.
        wr_en4   = 1'b1;
        wr_data4 = 8'h01;
        tick();
        k4     = cyc;
        wr_en4 = 1'b0;
        repeat (45) tick();
        check("baud_idle_before", {31'd0, hist4[k4+1]}, 32'd1);
        // 4 start + 28 zero-bit cycles low, then bit0 and stop high for 4 each.
        for (int i = 0; i < 40; i++) begin
            check("baud_wave", {31'd0, hist4[k4+2+i]}, (i < 32) ? 32'd0 : 32'd1);
        end
        check("baud_idle_after", {31'd0, hist4[k4+42]}, 32'd1);
        check("baud_busy_after", {31'd0, busy4}, 32'd0);
        check("baud_full", {31'd0, full4}, 32'd0);

        // Loopback into the receiver: 0xE0.
        base = rx_cnt;
        wr(8'hE0, k);
        for (int t = 0; t < 40 && rx_cnt == base; t++) tick();
        if (rx_cnt == base) check("loop_timeout", 32'd0, 32'd1);
        check("loop_data", {24'd0, rx_data}, 32'h0000_00E0);
        check("loop_rdy", {31'd0, rx_rdy}, 32'd1);
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
